gray_conv_scheduler: RTL and testbench
======================================

GRAY_CONV_SCHEDULER -- requirements
Module: gray_conv_scheduler

Interface
REQ-001 The block SHALL have parameter W, default 4: Gray/binary word width; legal range 2..16.
REQ-002 The block SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-004 The block SHALL have port req_valid, input, 4: per-requester request valid, requester i on bit i.
REQ-005 The block SHALL have port req_gray, input, 4*W: per-requester Gray word, requester i on bits [i*W +: W].
REQ-006 The block SHALL have port req_ready, output, 4: per-requester accept strobe, at most one bit high.
REQ-007 The block SHALL have port out_valid, output, 1: converted word available.
REQ-008 The block SHALL have port out_ready, input, 1: downstream accepts the word.
REQ-009 The block SHALL have port out_bin, output, W: binary result.
REQ-010 The block SHALL have port out_id, output, 2: index of the requester that supplied out_bin.
REQ-011 The block SHALL have port out_err, output, 1: Gray step-violation flag for the current word (see Configuration).

Function
REQ-012 The block SHALL share one Gray-to-binary datapath among 4 requesters: b[W-1]=g[W-1]; b[k]=b[k+1]^g[k].
REQ-013 The block SHALL treat a request transfer as req_valid[i] && req_ready[i] in the same cycle.
REQ-014 The block SHALL accept only while can_accept = !out_valid || out_ready.
REQ-015 req_ready SHALL be combinational: one-hot grant to the round-robin winner among valid requesters when can_accept is high, else 0.
REQ-016 Round-robin: the search SHALL start at the requester after the last granted one, wrapping 3->0, and the pointer SHALL move only on a transfer.
REQ-017 Latency SHALL be 1 cycle: a transfer in cycle k gives out_valid=1 with out_bin/out_id/out_err in cycle k+1.
REQ-018 The output register SHALL hold stable while out_valid && !out_ready.
REQ-019 out_valid SHALL clear when out_ready=1 and no transfer happens in the same cycle.
REQ-020 When out_ready=1 and a new transfer occur in the same cycle, the block SHALL load the new word so that throughput is one word per cycle.
REQ-021 A requester SHALL hold req_valid and req_gray stable until granted; the block SHALL NOT require this for correctness of other requesters.
REQ-022 Starvation bound: a continuously valid requester SHALL be granted within 4 transfers.
REQ-023 The block SHALL tolerate any value on out_ready while out_valid=0.

Reset
REQ-024 While rst_n=0 at a clock edge, the block SHALL set out_valid=0, out_bin=0, out_id=0, out_err=0, last-granted pointer=3 (so requester 0 has first priority), and clear all step-check history.
REQ-025 req_ready SHALL be 0 during any cycle with rst_n=0.
REQ-026 Reset asserted while out_valid=1 SHALL discard the pending word with no further output.

Configuration
REQ-027 The macro GRAY_STEP_CHECK_EN SHALL enable the step checker; all other behaviour SHALL be identical with and without it.
REQ-028 With GRAY_STEP_CHECK_EN defined, the block SHALL store per requester the last accepted Gray word and a seen flag.
REQ-029 With GRAY_STEP_CHECK_EN defined, out_err SHALL be 1 for a word whose Gray value differs from the same requester's previous word in more than 1 bit.
REQ-030 With GRAY_STEP_CHECK_EN defined, the first word from a requester after reset and a repeated identical word SHALL NOT flag.
REQ-031 Without GRAY_STEP_CHECK_EN, out_err SHALL be tied to 0 and no history storage SHALL be built.

Verification
REQ-032 The bench SHALL cover: after reset, req_valid=0001, req_gray[3:0]=0110, out_ready=1 -> next cycle out_valid=1, out_bin=0100, out_id=0.
REQ-033 The bench SHALL cover: all 4 valid for 8 cycles with out_ready=1 -> out_id sequence 0,1,2,3,0,1,2,3 and one word per cycle.
REQ-034 The bench SHALL cover: req 2 gray=1000, out_ready=0 for 3 cycles -> out_bin=1111 and out_id=2 held, req_ready=0; the word is consumed in the cycle out_ready=1.
REQ-035 The bench SHALL cover (GRAY_STEP_CHECK_EN): req 1 sends 0011 then 0010 then 1100 -> out_err 0,0,1 with out_bin 0010,0011,1000.
REQ-036 The bench SHALL cover: rst_n=0 for one cycle while out_valid=1 -> next cycle out_valid=0, and the next grant goes to requester 0 when all are valid.
REQ-037 The bench SHALL cover (macro undefined): the REQ-035 stimulus -> out_err=0 throughout.

Source files
------------

// File: rtl/gray_conv_scheduler.sv
// gray_conv_scheduler: four requesters share one Gray-to-binary converter.
// A round-robin arbiter grants one requester per cycle into a single
// output register that has 1-cycle latency and full-throughput backpressure.
// Optional feature macro: GRAY_STEP_CHECK_EN. When it is defined, the block
// keeps a per-requester Gray history and flags words that jump by more than
// one bit on out_err.
module gray_conv_scheduler #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [3:0]     req_valid,
    input  logic [4*W-1:0] req_gray,
    output logic [3:0]     req_ready,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_bin,
    output logic [1:0]     out_id,
    output logic           out_err
);

    logic [3:0][W-1:0] lane_gray;
    logic [1:0]        last_ptr;
    logic [3:0]        grant;
    logic [1:0]        win_id;
    logic [W-1:0]      win_gray;
    logic              can_accept;
    logic              xfer;

    assign lane_gray = req_gray;

    function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int k = W - 2; k >= 0; k--) b[k] = b[k+1] ^ g[k];
        return b;
    endfunction

    // Round-robin search that starts just after the last granted requester.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        grant  = '0;
        win_id = 2'd0;
        found  = 1'b0;
        idx    = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_ptr + 2'(k);
            if (!found && req_valid[idx]) begin
                grant[idx] = 1'b1;
                win_id     = idx;
                found      = 1'b1;
            end
        end
    end

    // Grants are gated by output-slot space and by reset, so nothing is
    // accepted while rst_n is low.
    always_comb begin
        can_accept = !out_valid || out_ready;
        req_ready  = (rst_n && can_accept) ? grant : 4'b0000;
        xfer       = |req_ready;
        win_gray   = lane_gray[win_id];
    end

    // Output register: load on transfer, drain on out_ready, otherwise hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_bin   <= '0;
            out_id    <= 2'd0;
            last_ptr  <= 2'd3;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_bin   <= gray2bin(win_gray);
            out_id    <= win_id;
            last_ptr  <= win_id;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef GRAY_STEP_CHECK_EN
    localparam logic [W-1:0] ONE = W'(1);

    logic [3:0][W-1:0] hist;
    logic [3:0]        seen;
    logic [W-1:0]      diff;
    logic              step_err;
    logic              err_q;

    // More than one differing bit means diff is not zero and not a power of two.
    always_comb begin
        diff     = hist[win_id] ^ win_gray;
        step_err = seen[win_id] && ((diff & (diff - ONE)) != '0);
    end

    // Per-requester history updates only on that requester's transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist  <= '0;
            seen  <= '0;
            err_q <= 1'b0;
        end else if (xfer) begin
            hist[win_id] <= win_gray;
            seen[win_id] <= 1'b1;
            err_q        <= step_err;
        end
    end

    assign out_err = err_q;
`else
    assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_conv_scheduler.sv
// Testbench for gray_conv_scheduler: directed scenarios followed by random
// traffic, all compared against a transaction-level reference model.
module tb_gray_conv_scheduler;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [3:0]     req_valid = '0;
    logic [4*W-1:0] req_gray = '0;
    logic [3:0]     req_ready;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [W-1:0]   out_bin;
    logic [1:0]     out_id;
    logic           out_err;

    always #5 clk = ~clk;

    gray_conv_scheduler #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_gray(req_gray),
        .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_bin(out_bin), .out_id(out_id), .out_err(out_err)
    );

    int total = 0;
    int bad = 0;

    // reference model state
    logic         m_valid = 1'b0;
    logic [W-1:0] m_bin = '0;
    logic [1:0]   m_id = '0;
    logic         m_err = 1'b0;
    int           m_ptr = 3;
    logic [W-1:0] m_hist [4];
    logic         m_seen [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_bin(input logic [W-1:0] g);
        logic [W-1:0] b = '0;
        for (int s = 0; s < W; s++) b ^= (g >> s);
        return b;
    endfunction

    function automatic int ones(input logic [W-1:0] x);
        int n = 0;
        for (int b = 0; b < W; b++) n += int'(x[b]);
        return n;
    endfunction

    function automatic logic [4*W-1:0] lane(input int i, input logic [W-1:0] g);
        logic [4*W-1:0] r = '0;
        r[i*W +: W] = g;
        return r;
    endfunction

    // One clock cycle: drive, check grant mid-cycle, advance model, check outputs.
    task automatic step(input logic rs, input logic [3:0] v, input logic [4*W-1:0] g,
                        input logic rdy);
        int win;
        logic [3:0] exp_rdy;
        logic [W-1:0] gw;
        rst_n = rs; req_valid = v; req_gray = g; out_ready = rdy;
        #3;
        win = -1;
        if (rs && (!m_valid || rdy))
            for (int k = 1; k <= 4; k++)
                if (win < 0 && v[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
        exp_rdy = (win >= 0) ? 4'(1 << win) : 4'b0000;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        @(posedge clk);
        if (!rs) begin
            m_valid = 1'b0; m_bin = '0; m_id = '0; m_err = 1'b0; m_ptr = 3;
            for (int i = 0; i < 4; i++) begin m_seen[i] = 1'b0; m_hist[i] = '0; end
        end else if (win >= 0) begin
            gw = g[win*W +: W];
            m_valid = 1'b1;
            m_bin = ref_bin(gw);
            m_id = 2'(win);
`ifdef GRAY_STEP_CHECK_EN
            m_err = m_seen[win] && (ones(m_hist[win] ^ gw) > 1);
`else
            m_err = 1'b0;
`endif
            m_hist[win] = gw;
            m_seen[win] = 1'b1;
            m_ptr = win;
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_bin", 32'(out_bin), 32'(m_bin));
        chk("out_id", 32'(out_id), 32'(m_id));
        chk("out_err", 32'(out_err), 32'(m_err));
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin m_seen[i] = 1'b0; m_hist[i] = '0; end

        // reset
        step(1'b0, 4'b1111, '1, 1'b1);
        step(1'b0, 4'b0000, '0, 1'b0);

        // single request from requester 0
        step(1'b1, 4'b0001, lane(0, 4'b0110), 1'b1);
        chk("basic_valid", 32'(out_valid), 32'd1);
        chk("basic_bin", 32'(out_bin), 32'h4);
        chk("basic_id", 32'(out_id), 32'd0);

        // all four valid: rotation 0,1,2,3,0,1,2,3 at one word per cycle
        step(1'b0, 4'b0000, '0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 4'b1111, 16'($urandom), 1'b1);
            chk("rr_id", 32'(out_id), 32'(k % 4));
            chk("rr_valid", 32'(out_valid), 32'd1);
        end

        // backpressure hold on requester 2
        step(1'b1, 4'b0000, '0, 1'b1);
        step(1'b1, 4'b0100, lane(2, 4'b1000), 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 4'b1111, 16'($urandom), 1'b0);
            chk("hold_bin", 32'(out_bin), 32'hF);
            chk("hold_id", 32'(out_id), 32'd2);
            chk("hold_valid", 32'(out_valid), 32'd1);
        end
        step(1'b1, 4'b0000, '0, 1'b1);
        chk("drain_valid", 32'(out_valid), 32'd0);

        // step checker sequence on requester 1
        step(1'b0, 4'b0000, '0, 1'b1);
        step(1'b1, 4'b0010, lane(1, 4'b0011), 1'b1);
        chk("sc1_bin", 32'(out_bin), 32'h2);
        chk("sc1_err", 32'(out_err), 32'd0);
        step(1'b1, 4'b0010, lane(1, 4'b0010), 1'b1);
        chk("sc2_bin", 32'(out_bin), 32'h3);
        chk("sc2_err", 32'(out_err), 32'd0);
        step(1'b1, 4'b0010, lane(1, 4'b1100), 1'b1);
        chk("sc3_bin", 32'(out_bin), 32'h8);
`ifdef GRAY_STEP_CHECK_EN
        chk("sc3_err", 32'(out_err), 32'd1);
`else
        chk("sc3_err", 32'(out_err), 32'd0);
`endif

        // reset while a word is pending
        step(1'b1, 4'b1000, lane(3, 4'b0101), 1'b0);
        chk("pend_valid", 32'(out_valid), 32'd1);
        step(1'b0, 4'b1111, 16'($urandom), 1'b0);
        chk("rst_drop", 32'(out_valid), 32'd0);
        step(1'b1, 4'b1111, 16'($urandom), 1'b1);
        chk("rst_first_id", 32'(out_id), 32'd0);

        // random traffic; single-bit perturbations keep the step checker busy
        for (int n = 0; n < 400; n++) begin
            logic [4*W-1:0] g;
            g = 16'($urandom);
            if ($urandom_range(0, 1) == 0) g = req_gray ^ 16'(1 << $urandom_range(0, 15));
            step(($urandom_range(0, 49) != 0), 4'($urandom_range(0, 15)), g,
                 ($urandom_range(0, 3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
